// File: rtl/fb_pkg.sv
// Shared frame-buffer geometry, intensity thresholds and scheduler state type
// for the bar-graph display path.
package fb_pkg;

  localparam int ROW_W = 4;
  localparam int COL_W = 4;
  localparam int VAL_W = 2;

  localparam logic [COL_W-1:0] THR_MID  = COL_W'(8);
  localparam logic [COL_W-1:0] THR_HIGH = COL_W'(12);
  localparam logic [COL_W-1:0] COL_LAST = '1;

  localparam logic [VAL_W-1:0] VAL_OFF  = 2'd0;
  localparam logic [VAL_W-1:0] VAL_LOW  = 2'd1;
  localparam logic [VAL_W-1:0] VAL_MID  = 2'd2;
  localparam logic [VAL_W-1:0] VAL_HIGH = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, pointer to
// the last granted requester updated only when the grant is consumed.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // last_ch1 resets high so requester 0 wins the first tie.
  logic last_ch1;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_ch1 ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_ch1 <= 1'b1;
    end else if (advance) begin
      last_ch1 <= gnt[1];
    end
  end

endmodule

// File: rtl/bar_graph_scheduler.sv
// Turns 12-bit ADC samples from two channels into 16-column bar-graph row
// rewrites in a frame buffer, one row per channel.
module bar_graph_scheduler
  import fb_pkg::*;
#(
  parameter int ROW_CH0 = 4,
  parameter int ROW_CH1 = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       ch_valid,
  input  logic [11:0]      ch_data0,
  input  logic [11:0]      ch_data1,
  output logic [1:0]       ch_ready,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [COL_W-1:0] wr_col,
  output logic [VAL_W-1:0] wr_val,
  input  logic             wr_ready,
  output logic             busy
);

  localparam logic [ROW_W-1:0] ROW0 = ROW_W'(ROW_CH0);
  localparam logic [ROW_W-1:0] ROW1 = ROW_W'(ROW_CH1);

  state_t           state;
  logic [COL_W-1:0] level;
  logic [1:0]       gnt;
  logic             handshake;
  logic [COL_W-1:0] cap_level;
  logic             unused_low_bits;

  function automatic logic [VAL_W-1:0] grade(input logic [COL_W-1:0] col,
                                             input logic [COL_W-1:0] lvl);
    if (col >= lvl)           return VAL_OFF;
    else if (col >= THR_HIGH) return VAL_HIGH;
    else if (col >= THR_MID)  return VAL_MID;
    else                      return VAL_LOW;
  endfunction

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (ch_valid),
    .advance (handshake),
    .gnt     (gnt)
  );

  // Both sides follow valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; ready is offered only in IDLE, the write
  // port holds its outputs while wr_ready is low.
  assign ch_ready        = (rst_n && state == IDLE) ? gnt : 2'b00;
  assign handshake       = |(ch_valid & ch_ready);
  assign cap_level       = ch_ready[1] ? ch_data1[11:8] : ch_data0[11:8];
  assign unused_low_bits = ^{ch_data0[7:0], ch_data1[7:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      level  <= '0;
      wr_en  <= 1'b0;
      busy   <= 1'b0;
      wr_row <= '0;
      wr_col <= '0;
      wr_val <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            state  <= WRITE;
            level  <= cap_level;
            wr_en  <= 1'b1;
            busy   <= 1'b1;
            wr_row <= ch_ready[1] ? ROW1 : ROW0;
            wr_col <= '0;
            wr_val <= grade('0, cap_level);
          end
        end
        WRITE: begin
          if (wr_ready) begin
            // The last column ends the rewrite; the counter never wraps here.
            if (wr_col == COL_LAST) begin
              state  <= IDLE;
              wr_en  <= 1'b0;
              busy   <= 1'b0;
              wr_row <= '0;
              wr_col <= '0;
              wr_val <= '0;
            end else begin
              wr_col <= wr_col + 1'b1;
              wr_val <= grade(wr_col + 1'b1, level);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bar_graph_scheduler.md
BAR_GRAPH_SCHEDULER -- requirements
Module: bar_graph_scheduler

Interface
REQ-001 SHALL have parameter ROW_CH0, default 4: frame-buffer row owned by channel 0.
REQ-002 SHALL have parameter ROW_CH1, default 11: frame-buffer row owned by channel 1; ROW_CH1 != ROW_CH0.
REQ-003 SHALL have port clk  input  1: single clock; every flop is on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port ch_valid  input  2: bit c means channel c offers a sample.
REQ-006 SHALL have port ch_data0  input  12: channel 0 ADC sample.
REQ-007 SHALL have port ch_data1  input  12: channel 1 ADC sample.
REQ-008 SHALL have port ch_ready  output  2: bit c means the sample on channel c is accepted this cycle.
REQ-009 SHALL have port wr_en  output  1: frame-buffer write request.
REQ-010 SHALL have port wr_row  output  4: target row.
REQ-011 SHALL have port wr_col  output  4: target column.
REQ-012 SHALL have port wr_val  output  2: intensity, 0 to 3.
REQ-013 SHALL have port wr_ready  input  1: the frame buffer accepts a write this cycle.
REQ-014 SHALL have port busy  output  1: high while a row rewrite is in progress.

Function
REQ-015 SHALL have states IDLE and WRITE only.
REQ-016 In IDLE, ch_ready SHALL be combinational: one-hot for the granted channel, 0 when no valid, always 0 in WRITE.
REQ-017 Arbitration SHALL be round-robin: a single request is granted; with both requesting, the channel not granted last wins.
REQ-018 Handshake SHALL complete on a rising edge with ch_valid[c] and ch_ready[c] both high; the module then captures level = ch_data[c][11:8], row = ROW_CHc, col = 0, and enters WRITE.
REQ-019 In WRITE, wr_en, busy = 1; wr_row = captured row; wr_col = column counter.
REQ-020 wr_val SHALL be 0 if col >= level; otherwise 3 if col >= 12, 2 if col >= 8, else 1.
REQ-021 Column counter SHALL advance only on edges with wr_en and wr_ready high; the outputs SHALL hold steady while wr_ready is low.
REQ-022 An accepted write at col 15 SHALL return the module to IDLE with wr_en = 0 next cycle; there is no wrap to col 0 within a rewrite.
REQ-023 A rewrite SHALL take exactly 16 accepted writes. The first write SHALL be presented the cycle after the handshake, giving 17 cycles per sample with wr_ready held high.
REQ-024 level 0 SHALL write sixteen zeros; level 15 SHALL light columns 0-14 and clear column 15.
REQ-025 A channel whose valid drops before grant SHALL be dropped with no state change. ch_data SHALL be sampled only at the handshake edge.
REQ-026 The module SHALL accept a new handshake on the IDLE cycle directly after a rewrite; no idle gap beyond that cycle.
REQ-027 wr_en SHALL be 0 whenever state is IDLE.

Reset
REQ-028 Asserting rst_n low SHALL immediately force: state IDLE, wr_en 0, wr_row 0, wr_col 0, wr_val 0, busy 0, ch_ready 0, last-grant pointer = channel 1 (so channel 0 wins first tie).
REQ-029 Reset mid-WRITE SHALL abandon the partial row; no resume after release.
REQ-030 After rst_n deasserts, the first handshake SHALL be possible on the first rising edge.

Structure
REQ-031 A shared package fb_pkg SHALL hold: ROW_W = 4, COL_W = 4, VAL_W = 2, thresholds 8 and 12, state enum (IDLE, WRITE).
REQ-032 The 2-requester round-robin grant logic SHALL be a sub-module rr_arbiter_2 (inputs req[1:0], advance; output one-hot gnt).
REQ-033 Sample-to-level mapping and intensity grading SHALL stay in bar_graph_scheduler.

Verification
REQ-034 ch_valid = 01, ch_data0 = 0xA00, wr_ready = 1 -> ch_ready = 01 for 1 cycle; 16 writes to row 4, cols 0-15, values 1×8, 2×2, 0×6; busy high 16 cycles.
REQ-035 ch_valid = 11 from reset, both data 0xF00 -> channel 0 first (row 4), channel 1 next (row 11). Each row gets values 1×8, 2×4, 3×3, 0×1; 34 cycles total.
REQ-036 wr_ready low for 5 cycles at col 7 -> wr_col, wr_val, wr_row held; the rewrite completes in 21 cycles.
REQ-037 ch_valid = 10 asserted during a channel-0 rewrite -> ch_ready stays 00 until IDLE, then 10 is granted.
REQ-038 rst_n pulsed low at col 9 -> wr_en 0 asynchronously. After release with ch_valid = 11, channel 0 is granted first.
REQ-039 ch_data0 = 0x0FF (level 0) -> 16 writes, all wr_val = 0.
